// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared widths, decoder opcodes and fetch FSM states
package instruction_fetch_pkg;

  localparam int ADDR_WIDTH    = 5;
  localparam int UNDEFINED     = 3;
  localparam int DATA_WIDTH    = 16;
  localparam int CNTR_WIDTH    = 8;
  localparam int COMBINED_DATA = ADDR_WIDTH + UNDEFINED + DATA_WIDTH;

  typedef enum logic [4:0] {
    OP_JMP = 5'd1,
    OP_JEZ = 5'd2,
    OP_JNZ = 5'd3,
    OP_JLZ = 5'd4,
    OP_JGZ = 5'd5,
    OP_RST = 5'd6,
    OP_NOP = 5'd7,
    OP_ST  = 5'd8
  } opcode_e;

  typedef enum logic [1:0] {
    S_REQ      = 2'd0,
    S_ISSUE    = 2'd1,
    S_ISSUE_PF = 2'd2,
    S_DRAIN    = 2'd3
  } ifetch_state_e;

endpackage

// File: rtl/instruction_fetch_pf_buf.sv
// rtl/instruction_fetch_pf_buf.sv - one-entry prefetch buffer (ifetch_pf_buf) with valid flag and discard
module ifetch_pf_buf #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             discard,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid
);

  // A write in the same cycle as a discard refills the entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
      valid   <= 1'b0;
    end else if (wr_en) begin
      rd_data <= wr_data;
      valid   <= 1'b1;
    end else if (discard) begin
      valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC owner and program-memory fetch front end for the decoder
// Optional IFETCH_PREFETCH_EN adds a one-entry speculative prefetch for 1 instr/cycle.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int CW = CNTR_WIDTH,
  parameter int DW = COMBINED_DATA
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          mem_req,
  output logic [CW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] instr,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          jmp,
  input  logic          rst_f,
  output logic [CW-1:0] pc
);

  ifetch_state_e state, state_d;
  logic          mem_req_d, valid_d;
  logic [CW-1:0] mem_addr_d, pc_d, pc_seq, redir_pc;
  logic [DW-1:0] instr_d;
  logic          xfer, acked, redirect;

  assign xfer     = instr_valid & instr_ready;
  assign acked    = mem_req & mem_ack;
  assign redirect = ~rst_f | jmp;
  assign redir_pc = ~rst_f ? '0 : instr[CW-1:0];
  assign pc_seq   = pc + 1'b1;

`ifdef IFETCH_PREFETCH_EN
  logic [CW-1:0] tgt, tgt_d;
  logic [DW-1:0] pf_data;
  logic          pf_valid, pf_wr, pf_discard;

  ifetch_pf_buf #(.WIDTH(DW)) u_pf_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (pf_wr),
    .discard (pf_discard),
    .wr_data (mem_rdata),
    .rd_data (pf_data),
    .valid   (pf_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tgt <= '0;
    else        tgt <= tgt_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_REQ;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      pc          <= '0;
    end else begin
      state       <= state_d;
      mem_req     <= mem_req_d;
      mem_addr    <= mem_addr_d;
      instr       <= instr_d;
      instr_valid <= valid_d;
      pc          <= pc_d;
    end
  end

  always_comb begin
    state_d    = state;
    mem_req_d  = mem_req;
    mem_addr_d = mem_addr;
    instr_d    = instr;
    valid_d    = instr_valid;
    pc_d       = pc;
`ifdef IFETCH_PREFETCH_EN
    tgt_d      = tgt;
    pf_wr      = 1'b0;
    pf_discard = 1'b0;
`endif
    case (state)
      S_REQ: begin
        mem_req_d = 1'b1;
        if (acked) begin
          instr_d = mem_rdata;
          pc_d    = mem_addr;
          valid_d = 1'b1;
          state_d = S_ISSUE;
`ifdef IFETCH_PREFETCH_EN
          mem_addr_d = mem_addr + 1'b1;
`else
          mem_req_d  = 1'b0;
`endif
        end
      end
`ifdef IFETCH_PREFETCH_EN
      // A speculative fetch of pc+1 is always outstanding here.
      S_ISSUE: begin
        if (xfer) begin
          if (redirect) begin
            valid_d = 1'b0;
            if (!mem_ack) begin
              tgt_d   = redir_pc;
              state_d = S_DRAIN;
            end else begin
              mem_addr_d = redir_pc;
              state_d    = S_REQ;
            end
          end else if (acked) begin
            instr_d    = mem_rdata;
            pc_d       = mem_addr;
            mem_addr_d = mem_addr + 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = S_REQ;
          end
        end else if (acked) begin
          pf_wr     = 1'b1;
          mem_req_d = 1'b0;
          state_d   = S_ISSUE_PF;
        end
      end
      S_ISSUE_PF: begin
        if (xfer && pf_valid) begin
          pf_discard = 1'b1;
          mem_req_d  = 1'b1;
          if (redirect) begin
            valid_d    = 1'b0;
            mem_addr_d = redir_pc;
            state_d    = S_REQ;
          end else begin
            instr_d    = pf_data;
            pc_d       = pc_seq;
            mem_addr_d = pc_seq + 1'b1;
            state_d    = S_ISSUE;
          end
        end
      end
      S_DRAIN: begin
        if (acked) begin
          mem_addr_d = tgt;
          state_d    = S_REQ;
        end
      end
`else
      S_ISSUE: begin
        if (xfer) begin
          valid_d    = 1'b0;
          mem_req_d  = 1'b1;
          mem_addr_d = redirect ? redir_pc : pc_seq;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_REQ;
`endif
    endcase
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack = 1'b0;
  logic [23:0] mem_rdata = '0;
  logic [23:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic        jmp = 1'b0;
  logic        rst_f = 1'b1;
  logic [7:0]  pc;

  logic [23:0] rom [0:255];
  int pass_cnt = 0;
  int total_cnt = 0;
  int mem_delay = 0;
  int wait_cnt = 0;
  int cyc = 0;
  int last_xfer = 0;
  int xfer_gap = 0;
  int n_xfer = 0;

  instruction_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jmp         (jmp),
    .rst_f       (rst_f),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Program memory: answers mem_delay cycles after the request first appears.
  always @(posedge clk) begin
    #1;
    if (!rst_n || !mem_req) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else begin
      if (mem_ack) wait_cnt = 0;
      if (wait_cnt >= mem_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = rom[mem_addr];
      end else begin
        mem_ack = 1'b0;
        wait_cnt++;
      end
    end
  end

  // Reference model: the issued stream is rom[] walked in program order.
  logic [7:0]  exp_pc = '0;
  logic [23:0] word;
  logic        p_valid, p_req, p_ack, p_ready, have_prev = 1'b0;
  logic [7:0]  p_addr, p_pc;
  logic [23:0] p_instr;

  always @(negedge clk) begin
    if (!rst_n) begin
      have_prev = 1'b0;
      exp_pc    = '0;
    end else begin
      cyc++;
      if (have_prev) begin
        if (p_req && !p_ack) begin
          chk("req_held", {31'd0, mem_req}, 32'd1);
          chk("addr_held", {24'd0, mem_addr}, {24'd0, p_addr});
        end
        if (p_valid && !p_ready) begin
          chk("stall_valid", {31'd0, instr_valid}, 32'd1);
          chk("stall_instr", {8'd0, instr}, {8'd0, p_instr});
          chk("stall_pc", {24'd0, pc}, {24'd0, p_pc});
        end
      end
      if (mem_req && mem_ack)
        chk("fetch_addr", {24'd0, mem_addr}, {24'd0, exp_pc});
      if (instr_valid && instr_ready) begin
        chk("xfer_pc", {24'd0, pc}, {24'd0, exp_pc});
        chk("xfer_instr", {8'd0, instr}, {8'd0, rom[exp_pc]});
        word = rom[exp_pc];
        if (!rst_f)   exp_pc = 8'd0;
        else if (jmp) exp_pc = word[7:0];
        else          exp_pc = exp_pc + 8'd1;
        xfer_gap  = cyc - last_xfer;
        last_xfer = cyc;
        n_xfer++;
      end
      p_valid = instr_valid; p_ready = instr_ready; p_req = mem_req; p_ack = mem_ack;
      p_addr = mem_addr; p_pc = pc; p_instr = instr; have_prev = 1'b1;
    end
  end

  task automatic wait_issue(input logic [7:0] target);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(posedge clk); #1;
      if (instr_valid && pc == target) found = 1'b1;
    end
    chk($sformatf("reach_pc_%0h", target), {31'd0, found}, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_mem_addr"}, {24'd0, mem_addr}, 32'd0);
    chk({tag, "_instr"}, {8'd0, instr}, 32'd0);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_pc"}, {24'd0, pc}, 32'd0);
  endtask

  initial begin
    int lat;
    int n0;
    for (int i = 0; i < 256; i++) rom[i] = {OP_NOP, 3'b000, 16'(i * 7 + 256)};
    rom[1]     = {OP_JMP, 3'b000, 16'h12FE};
    rom[5]     = {OP_JMP, 3'b000, 16'h00A3};
    rom[8'hA4] = {OP_RST, 3'b000, 16'h0055};

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (instr_valid) lat = i;
    end
    chk("first_valid_latency", lat, 2);
    chk("first_pc", {24'd0, pc}, 32'd0);

    wait_issue(8'd5);
    chk("seq_cycles_per_instr", xfer_gap, 2);
    jmp = 1'b1;
    @(posedge clk); #1;
    jmp = 1'b0;
    chk("jmp_req", {31'd0, mem_req}, 32'd1);
    chk("jmp_addr", {24'd0, mem_addr}, 32'h0000_00A3);
    wait_issue(8'hA3);

    n0 = n_xfer;
    instr_ready = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("stall_no_xfer", n_xfer, n0);
    chk("stall_pc_a3", {24'd0, pc}, 32'h0000_00A3);
    chk("stall_valid_hi", {31'd0, instr_valid}, 32'd1);
    instr_ready = 1'b1;

    wait_issue(8'hA4);
    jmp = 1'b1;
    rst_f = 1'b0;
    @(posedge clk); #1;
    jmp = 1'b0;
    rst_f = 1'b1;
    chk("rstf_wins_addr", {24'd0, mem_addr}, 32'd0);
    chk("rstf_wins_req", {31'd0, mem_req}, 32'd1);

    wait_issue(8'd0);
    mem_delay = 3;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("slow_req_%0d", i), {31'd0, mem_req}, 32'd1);
      chk($sformatf("slow_addr_%0d", i), {24'd0, mem_addr}, 32'd1);
      chk($sformatf("slow_valid_%0d", i), {31'd0, instr_valid}, 32'd0);
      if (i < 3) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    chk("slow_valid_after_ack", {31'd0, instr_valid}, 32'd1);
    chk("slow_pc", {24'd0, pc}, 32'd1);
    mem_delay = 0;

    jmp = 1'b1;
    @(posedge clk); #1;
    jmp = 1'b0;
    chk("jmp_truncated_addr", {24'd0, mem_addr}, 32'h0000_00FE);

    wait_issue(8'hFF);
    @(posedge clk); #1;
    chk("wrap_req", {31'd0, mem_req}, 32'd1);
    chk("wrap_addr", {24'd0, mem_addr}, 32'd0);

    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_issue(8'd3);
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Front end of the CPU: owns the program counter, fetches instruction words from program memory and presents them to the instruction decoder's data_in.
- Consumes the decoder's jmp / rst_f outputs to redirect the PC, closing the fetch→decode loop.
- Sits between program ROM/RAM and instruction_decoder; one instruction in flight to execute.

Parameters:
- ADDR_WIDTH, 5, opcode field width (top bits of the instruction word).
- UNDEFINED, 3, unused field between opcode and data.
- DATA_WIDTH, 16, data/operand field width.
- CNTR_WIDTH, 8, program counter width; program memory holds 2^CNTR_WIDTH words.
- COMBINED_DATA, ADDR_WIDTH+UNDEFINED+DATA_WIDTH, instruction word width (24).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_req  out  1  program memory read request.
- mem_addr  out  CNTR_WIDTH  read address; stable while mem_req=1.
- mem_ack  in  1  read complete; mem_rdata valid this cycle.
- mem_rdata  in  COMBINED_DATA  instruction word from memory.
- instr  out  COMBINED_DATA  instruction to decoder data_in.
- instr_valid  out  1  instr holds a valid instruction.
- instr_ready  in  1  execute stage consumes instr this cycle.
- jmp  in  1  decoder: taken jump for current instr.
- rst_f  in  1  decoder: active-low soft reset (RST opcode).
- pc  out  CNTR_WIDTH  address of the instruction currently on instr.

Behaviour:
- Async reset: pc=0, mem_req=0, mem_addr=0, instr=0, instr_valid=0, state=S_REQ, all prefetch state cleared.
- Issue handshake: instr transfers when instr_valid & instr_ready. instr and instr_valid are held stable until the transfer.
- Memory handshake: mem_req and mem_addr are held until mem_ack. mem_ack is ignored when mem_req=0. A zero-wait ack in the first request cycle is legal.
- FSM states (base build):
  - S_REQ: mem_req=1, mem_addr=pc_next. On mem_ack: instr<=mem_rdata, go to S_ISSUE. Otherwise stay in S_REQ.
  - S_ISSUE: instr_valid=1. On transfer, jmp/rst_f are sampled in the same cycle:
    - rst_f=0 → pc_next=0, highest priority.
    - else jmp=1 → pc_next=instr[CNTR_WIDTH-1:0].
    - else pc_next=pc+1.
    - Then go to S_REQ with instr_valid=0.
  - pc updates to pc_next when the fetched word is captured.
- Throughput (base build): zero-wait memory gives 2 cycles per instruction; latency from reset release to first instr_valid is 2 cycles.
- Wrap-around: pc+1 at 2^CNTR_WIDTH-1 wraps to 0 silently.
- Jump target is truncated to CNTR_WIDTH; data bits above it are ignored.
- jmp=1 together with rst_f=0: rst_f wins, pc=0.
- jmp and rst_f are don't-care when no transfer occurs.
- rst_n asserted mid-request drops mem_req immediately; program memory tolerates an abandoned request.

Optional Feature:
- Macro: IFETCH_PREFETCH_EN.
- Defined:
  - Adds a one-entry prefetch buffer and states S_ISSUE_PF and S_DRAIN.
  - While in S_ISSUE, the block requests pc+1 speculatively. The returning word is stored in pf_buf with pf_valid=1.
  - Sequential transfer with pf_valid, or with mem_ack in the same cycle: instr loads the prefetched word and instr_valid stays 1, giving 1 instruction per cycle.
  - Redirect (jmp, or rst_f=0) while a prefetch is outstanding: go to S_DRAIN and wait for mem_ack. The drained data is discarded, then the block goes to S_REQ with the new target. A completed pf_buf is simply invalidated.
- Undefined: base 2-cycle FSM only; no prefetch hardware.

Decomposition:
- Shared package/header: opcode defines (JMP, JEZ, JNZ, JLZ, JGZ, RST, NOP, ST), shared with the decoder.
- Shared package/header: default width constants ADDR_WIDTH, UNDEFINED, DATA_WIDTH, CNTR_WIDTH.
- Shared package/header: FSM state encodings.
- One natural sub-module: ifetch_pf_buf, the one-entry buffer with valid flag and discard input, instantiated only under IFETCH_PREFETCH_EN.

Test Plan:
- Reset release, zero-wait memory, instr_ready=1, no jumps:
  - addresses 0,1,2,3 requested; instr_valid first high 2 cycles after release;
  - pc matches each issued word;
  - 2 cycles/instr (1 with IFETCH_PREFETCH_EN).
- At pc=5, issue a JMP word with data field 0x00A3 and jmp=1 on transfer:
  - next mem_addr=0xA3; pc=0xA3;
  - under prefetch, the speculative word for 6 is drained and never appears on instr.
- jmp=1 and rst_f=0 in the same transfer cycle → next mem_addr=0, pc=0.
- Memory ack delayed 3 cycles:
  - mem_req/mem_addr stay stable for all 4 cycles;
  - instr_valid stays 0 until the cycle after ack.
- instr_ready low for 4 cycles: instr, pc and instr_valid stay constant; no new transfer occurs.
- Sequential run from pc=0xFF → next fetch address 0x00; rst_n pulsed mid-request → mem_req=0 and all outputs reset asynchronously.
